// File: rtl/conv_tap_mac.sv
// conv_tap_mac: convolution tap multiply-accumulate.
//
// Consumes the tmg control stream. Each enabled cycle selects one of the nine
// 3x3 window taps. The selected pixel is multiplied by its stored weight, and
// the product is accumulated with saturation. muxcontrol1 opens a window,
// which clears the accumulator. muxcontrol2 closes the window and emits the
// result.
//
// Handshake: en is a valid-only strobe. There is no ready signal and no
// backpressure. A control sample is consumed on every rising edge where
// en=1, and is ignored entirely when en=0. The downstream stage must accept
// every result_valid pulse.
//
// Optional feature: define CONV_TAP_RELU_EN to apply ReLU to the emitted
// result. When it is undefined, the result is a signed passthrough.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                control-stream valid
//   muxcontrol1       open window (clear accumulator)
//   muxcontrol2       close window (emit result)
//   muxout[3:0]       tap index: 0-8 tap, 15 idle, 9-14 illegal
//   pix_in, wgt_in    nine packed signed DATA_W values, tap k at [k*DATA_W +: DATA_W]
//   wgt_load          capture wgt_in into the weight bank
//   result            signed window result
//   result_valid      one-cycle pulse qualifying result
//   busy              window open
//   code_err          sticky illegal-code flag
module conv_tap_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     muxcontrol1,
  input  logic                     muxcontrol2,
  input  logic [3:0]               muxout,
  input  logic [9*DATA_W-1:0]      pix_in,
  input  logic [9*DATA_W-1:0]      wgt_in,
  input  logic                     wgt_load,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     code_err
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DATA_W-1:0] wgt_q [9];
  logic signed [DATA_W-1:0] pix_sel;
  logic signed [DATA_W-1:0] wgt_sel;
  logic                     tap_ok;
  logic                     tap_bad;
  logic signed [PROD_W-1:0] prod_comb;

  // Stage 1 registers
  logic signed [PROD_W-1:0] prod_r;
  logic                     prod_v;
  logic                     clr_d;
  logic                     cls_d;

  // Stage 2
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    base_w;
  logic signed [ACC_W:0]    add_w;
  logic signed [ACC_W:0]    sum_w;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  act;

  // Tap select reads the registered weights. A same-cycle reload therefore
  // only takes effect on the following edge.
  always_comb begin
    pix_sel = '0;
    wgt_sel = '0;
    for (int k = 0; k < 9; k++) begin
      if (muxout == 4'(k)) begin
        pix_sel = pix_in[k*DATA_W +: DATA_W];
        wgt_sel = wgt_q[k];
      end
    end
  end

  assign tap_ok    = en && (muxout <= 4'd8);
  assign tap_bad   = en && (muxout >= 4'd9) && (muxout <= 4'd14);
  assign prod_comb = PROD_W'(pix_sel) * PROD_W'(wgt_sel);

  // Weight bank
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) wgt_q[k] <= '0;
    end else if (wgt_load) begin
      for (int k = 0; k < 9; k++) wgt_q[k] <= wgt_in[k*DATA_W +: DATA_W];
    end
  end

  // Stage 1: fetch / multiply, control delay, busy and error flags.
  // A close wins over an open in the busy update. This keeps busy at 0 when
  // both arrive together.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r   <= '0;
      prod_v   <= 1'b0;
      clr_d    <= 1'b0;
      cls_d    <= 1'b0;
      busy     <= 1'b0;
      code_err <= 1'b0;
    end else begin
      prod_v <= tap_ok;
      if (tap_ok) prod_r <= prod_comb;
      clr_d <= en & muxcontrol1;
      cls_d <= en & muxcontrol2;
      if (en && muxcontrol2)      busy <= 1'b0;
      else if (en && muxcontrol1) busy <= 1'b1;
      if (tap_bad) code_err <= 1'b1;
    end
  end

  // Stage 2: clear, then add, then saturate. Both operands fit in ACC_W bits,
  // so one extra bit is enough to detect overflow.
  always_comb begin
    base_w = '0;
    add_w  = '0;
    if (!clr_d) base_w = (ACC_W+1)'(acc);
    if (prod_v) add_w = (ACC_W+1)'(prod_r);
    sum_w = base_w + add_w;
    if (sum_w[ACC_W] != sum_w[ACC_W-1]) acc_next = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    else                                acc_next = sum_w[ACC_W-1:0];
  end

`ifdef CONV_TAP_RELU_EN
  assign act = acc_next[ACC_W-1] ? '0 : acc_next;
`else
  assign act = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      acc          <= acc_next;
      result_valid <= cls_d;
      if (cls_d) result <= act;
    end
  end

endmodule

// File: tb/tb_conv_tap_mac.sv
module tb_conv_tap_mac;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam longint SAT_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint SAT_MIN = -(64'sd1 <<< (ACC_W-1));

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic                    muxcontrol1 = 1'b0;
  logic                    muxcontrol2 = 1'b0;
  logic [3:0]              muxout = 4'd15;
  logic [9*DATA_W-1:0]     pix_in = '0;
  logic [9*DATA_W-1:0]     wgt_in = '0;
  logic                    wgt_load = 1'b0;
  logic signed [ACC_W-1:0] result;
  logic                    result_valid;
  logic                    busy;
  logic                    code_err;

  conv_tap_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .muxcontrol1(muxcontrol1),
    .muxcontrol2(muxcontrol2), .muxout(muxout), .pix_in(pix_in),
    .wgt_in(wgt_in), .wgt_load(wgt_load), .result(result),
    .result_valid(result_valid), .busy(busy), .code_err(code_err)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit started = 0;
  logic signed [ACC_W-1:0] exp_q[$];
  int cyc_q[$];
  longint last_result = 0;

  // reference model: window-level arithmetic on plain integers
  longint m_acc  = 0;
  bit     m_busy = 0;
  bit     m_err  = 0;
  int     m_wgt [9];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  function automatic longint act(input longint v);
`ifdef CONV_TAP_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int pix_at(input int k);
    logic signed [DATA_W-1:0] t;
    t = pix_in[k*DATA_W +: DATA_W];
    return int'(t);
  endfunction

  function automatic int wgt_at(input int k);
    logic signed [DATA_W-1:0] t;
    t = wgt_in[k*DATA_W +: DATA_W];
    return int'(t);
  endfunction

  // Apply one sampled control word to the model, in stream order.
  task automatic model_sample();
    if (rst) begin
      m_acc = 0; m_busy = 0; m_err = 0;
      for (int k = 0; k < 9; k++) m_wgt[k] = 0;
      exp_q.delete();
      cyc_q.delete();
    end else begin
      if (en) begin
        if (muxcontrol1) m_acc = 0;
        if (muxout <= 4'd8)
          m_acc = sat(m_acc + longint'(pix_at(int'(muxout))) * m_wgt[int'(muxout)]);
        else if (muxout <= 4'd14)
          m_err = 1;
        if (muxcontrol2) begin
          exp_q.push_back(ACC_W'(act(m_acc)));
          cyc_q.push_back(cyc + 1);
        end
        if (muxcontrol2)      m_busy = 0;
        else if (muxcontrol1) m_busy = 1;
      end
      if (wgt_load) for (int k = 0; k < 9; k++) m_wgt[k] = wgt_at(k);
    end
  endtask

  // driver
  task automatic step(input logic e, input logic o, input logic c,
                      input logic [3:0] m, input logic ld);
    en = e; muxcontrol1 = o; muxcontrol2 = c; muxout = m; wgt_load = ld;
    @(posedge clk);
    cyc++;
    model_sample();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd15, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'd15, 1'b0);
    rst = 1'b0;
  endtask

  task automatic load_w_all(input int v);
    for (int k = 0; k < 9; k++) wgt_in[k*DATA_W +: DATA_W] = DATA_W'(v);
    step(1'b0, 1'b0, 1'b0, 4'd15, 1'b1);
  endtask

  task automatic set_pix_all(input int v);
    for (int k = 0; k < 9; k++) pix_in[k*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  task automatic set_pix_ramp();
    for (int k = 0; k < 9; k++) pix_in[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
  endtask

  task automatic window_0_to_8();
    for (int k = 0; k < 9; k++) step(1'b1, k == 0, k == 8, 4'(k), 1'b0);
    idle(3);
  endtask

  task automatic long_window(input int n);
    for (int i = 0; i < n; i++) step(1'b1, i == 0, i == n - 1, 4'(i % 9), 1'b0);
    idle(3);
  endtask

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("busy", busy, m_busy);
      check("code_err", code_err, m_err);
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("result", longint'(result), longint'(exp_q.pop_front()));
          check("valid_cycle", cyc, cyc_q.pop_front());
          last_result = longint'(result);
        end
      end
    end
  end

  initial begin
    do_reset();
    started = 1;
    check("rst_result", longint'(result), 0);
    check("rst_valid", result_valid, 0);

    // 1: weights 1, pixels 1..9
    load_w_all(1);
    set_pix_ramp();
    window_0_to_8();
    check("t1_sum", last_result, 45);

    // 2: weights -1
    load_w_all(-1);
    window_0_to_8();
`ifdef CONV_TAP_RELU_EN
    check("t2_sum", last_result, 0);
`else
    check("t2_sum", last_result, -45);
`endif

    // 3: positive saturation
    load_w_all(127);
    set_pix_all(127);
    long_window(40);
    check("t3_sat_pos", last_result, 524287);

    // negative saturation
    load_w_all(-128);
    long_window(40);
`ifdef CONV_TAP_RELU_EN
    check("sat_neg", last_result, 0);
`else
    check("sat_neg", last_result, -524288);
`endif

    // same-cycle reload uses the old weight
    load_w_all(1);
    set_pix_ramp();
    for (int k = 0; k < 9; k++) wgt_in[k*DATA_W +: DATA_W] = 8'sd2;
    step(1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
    idle(3);
    check("old_wgt", last_result, 1);

    // 4: illegal code inside a window
    load_w_all(1);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'b1010, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
    idle(3);
    check("t4_sum", last_result, 3);
    check("t4_err", code_err, 1);

    // 5: open+close on tap 4
    do_reset();
    pix_in[4*DATA_W +: DATA_W] = 8'sd5;
    wgt_in = '0;
    wgt_in[4*DATA_W +: DATA_W] = -8'sd3;
    step(1'b0, 1'b0, 1'b0, 4'd15, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'd4, 1'b0);
    check("t5_busy", busy, 0);
    idle(3);
`ifdef CONV_TAP_RELU_EN
    check("t5_sum", last_result, 0);
`else
    check("t5_sum", last_result, -15);
`endif

    // 6: reset right after a close, and a close with en=0
    step(1'b1, 1'b1, 1'b0, 4'd4, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd4, 1'b0);
    do_reset();
    idle(3);
    check("t6_result", longint'(result), 0);
    check("t6_busy", busy, 0);
    check("t6_err", code_err, 0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    idle(3);

    // randomized stream
    for (int i = 0; i < 2000; i++) begin
      logic e, o, c, ld;
      logic [3:0] m;
      for (int k = 0; k < 9; k++) pix_in[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      ld = ($urandom_range(0, 9) == 0);
      if (ld) for (int k = 0; k < 9; k++) wgt_in[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      e = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) m = 4'($urandom_range(9, 15));
      else                            m = 4'($urandom_range(0, 8));
      rst = ($urandom_range(0, 199) == 0);
      step(e, o, c, m, ld);
    end
    rst = 1'b0;
    idle(4);
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_tap_mac.md
# conv_tap_mac

Convolution tap accumulator: the consumer of the `tmg` control stream (`en`, `muxcontrol1`, `muxcontrol2`, `muxout`) in the CNN processor datapath.

- Each enabled cycle, `muxout` selects one of nine 3x3 window taps.
- The block multiplies the selected pixel by its stored weight and accumulates the product with saturation.
- `muxcontrol1` opens a window (clears the accumulator); `muxcontrol2` closes it and emits the result.
- It sits between the window buffer (pixels), the weight loader, and the downstream pooling/activation stage.

## Interface

Parameters:
- `DATA_W`, 8: signed pixel and weight width.
- `ACC_W`, 20: signed accumulator and result width; must be ≥ 2*`DATA_W`+4.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: control-stream valid. When low, all other control inputs are ignored.
- `muxcontrol1` in 1: open window (clear accumulator).
- `muxcontrol2` in 1: close window (emit result).
- `muxout` in 4: tap index.
  - 0–8: tap select.
  - 15: idle.
  - 9–14: illegal.
- `pix_in` in 9*`DATA_W`: packed signed window pixels; tap k occupies bits [k*`DATA_W` +: `DATA_W`].
- `wgt_in` in 9*`DATA_W`: packed signed weights, same packing as `pix_in`.
- `wgt_load` in 1: capture `wgt_in` into the internal weight registers.
- `result` out `ACC_W`: signed window result.
- `result_valid` out 1: one-cycle pulse; `result` is valid in that cycle.
- `busy` out 1: window open.
- `code_err` out 1: sticky illegal-code flag.

## Operation

- Weight bank: nine `DATA_W` registers, written on any cycle with `wgt_load`=1.
  - If a tap uses a weight in the same cycle it is reloaded, the tap uses the old value.
- Stage 1 (fetch/multiply), evaluated on each edge:
  - If `en`=1 and `muxout`≤8: `prod_r` ← pix[muxout] × wgt[muxout], full 2*`DATA_W` signed, and `prod_v` ← 1. Otherwise `prod_v` ← 0.
  - `clr_d` ← `en`&`muxcontrol1`; `cls_d` ← `en`&`muxcontrol2`.
  - If `en`=1 and `muxout` is 9–14: `code_err` ← 1, and no product is formed.
- Stage 2 (accumulate), on the following edge:
  - Base value = 0 if `clr_d`, else `acc`.
  - Next value = saturate(base + (`prod_v` ? sign-extended `prod_r` : 0)).
  - Saturation limits: −2^(`ACC_W`−1) and 2^(`ACC_W`−1)−1. No wrap-around is permitted.
  - `acc` ← next value.
  - If `cls_d`: `result` ← activation(next value) and `result_valid` ← 1; otherwise `result_valid` ← 0 and `result` holds.
- Simultaneous open and close on one sample: apply the clear, then the tap product, then emit. The result equals that single product.
- Close without a prior open: emits the current accumulator value; this is legal.
- A second open while the window is open: restarts the accumulation; the discarded partial sum is not reported.
- `busy`:
  - Set the cycle after an open.
  - Cleared the cycle after a close.
  - If open and close arrive together, `busy` stays 0.
- Reset mid-window:
  - Pipeline is flushed; no `result_valid` is produced for the interrupted window.
  - All registers, including weights and `code_err`, return to 0.

## Timing

- Reset values: `result`=0, `result_valid`=0, `busy`=0, `code_err`=0. Internal state `acc`=0, `prod_r`=0, `prod_v`=0, and all weights=0.
- Latency: a close sampled at edge E produces `result_valid`=1 in the cycle after edge E+1, i.e. 2 cycles after the close is presented.
- Throughput: one tap per cycle; back-to-back windows are allowed with no bubble.
- `code_err` asserts 1 cycle after the illegal code is sampled and holds until `rst`.
- The block has no backpressure. The consumer must accept every `result_valid` pulse.

## Configuration

- `CONV_TAP_RELU_EN` defined: activation(x) = x<0 ? 0 : x. `result` is never negative.
- `CONV_TAP_RELU_EN` undefined: activation(x) = x. `result` is a signed passthrough.

## Test plan

1. Load all weights = 1 and `pix_in` taps 0..8 = 1..9. Present taps 0..8 on consecutive `en` cycles, with open on tap 0 and close on tap 8. Required: `result`=45, and `result_valid` is high exactly one cycle, 2 cycles after tap 8 is presented.
2. Load weights = −1 with the same pixels and the same window. Required: `result`=−45 without `CONV_TAP_RELU_EN`; `result`=0 with it.
3. Load all weights and pixels = 127, then present 40 taps in one window. Required: `result`=524287 (saturated, no wrap).
4. Present `muxout`=4'b1010 with `en`=1 inside a window of taps {0,1}, weights = 1, pixels = 1..9. Required: `result`=3, and `code_err`=1 until `rst`.
5. Present open+close in the same cycle on tap 4, with pix4=5 and wgt4=−3. Required: `result`=−15 without ReLU, and `busy` stays 0.
6. Assert `rst` one cycle after a close, and separately present `muxcontrol2`=1 with `en`=0. Required: no `result_valid` pulse in either case, and all outputs read 0 after reset.
